// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic              valid;
        reg_addr_t         wa;
        logic [DATA_W-1:0] wd;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback handshakes, decode hazard queries and the register-file write port.
interface regfile_wb_arbiter_if;
    import regfile_pkg::*;

    logic                alu_valid;
    logic                alu_ready;
    reg_addr_t           alu_wa;
    logic [DATA_W-1:0]   alu_wd;

    logic                mem_valid;
    logic                mem_ready;
    reg_addr_t           mem_wa;
    logic [DATA_W-1:0]   mem_wd;

    logic                issue_valid;
    reg_addr_t           issue_wa;
    logic                issue_ready;

    reg_addr_t           ra1;
    reg_addr_t           ra2;
    logic                hazard1;
    logic                hazard2;
    logic                busy;

    logic                we3;
    reg_addr_t           wa3;
    logic [DATA_W-1:0]   wd3;

    // Arbiter side
    modport slave (
        input  alu_valid, alu_wa, alu_wd,
        input  mem_valid, mem_wa, mem_wd,
        input  issue_valid, issue_wa, ra1, ra2,
        output alu_ready, mem_ready, issue_ready,
        output hazard1, hazard2, busy,
        output we3, wa3, wd3
    );

    // Pipeline / register-file side
    modport master (
        output alu_valid, alu_wa, alu_wd,
        output mem_valid, mem_wa, mem_wd,
        output issue_valid, issue_wa, ra1, ra2,
        input  alu_ready, mem_ready, issue_ready,
        input  hazard1, hazard2, busy,
        input  we3, wa3, wd3
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; req[0]/gnt[0] is ALU, req[1]/gnt[1] is MEM.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       CLK,
    input  logic       RESETn,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    wb_src_e last_grant_q;
    wb_src_e last_grant_d;

    // Grant: a lone requester wins; on conflict the one not granted last time wins.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant_q == SRC_MEM) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Pointer moves only when a handshake actually completes.
    always_comb begin
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = gnt[1] ? SRC_MEM : SRC_ALU;
        end
    end

    // Pointer register; MEM after reset so ALU wins the first conflict.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            last_grant_q <= SRC_MEM;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and MEM writeback and
// tracks which destination registers still await their write.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESETn,
    regfile_wb_arbiter_if.slave  bus
);

    wb_req_t             alu_req;
    wb_req_t             mem_req;
    logic [1:0]          gnt;
    logic                hs;
    reg_addr_t           win_wa;
    logic [DATA_W-1:0]   win_wd;

    logic                we3_q, we3_d;
    reg_addr_t           wa3_q, wa3_d;
    logic [DATA_W-1:0]   wd3_q, wd3_d;
    logic [NREGS-1:0]    pending_q, pending_d;
    logic                issue_ready;

    assign alu_req = {bus.alu_valid, bus.alu_wa, bus.alu_wd};
    assign mem_req = {bus.mem_valid, bus.mem_wa, bus.mem_wd};

    rr_arbiter2 u_arb (
        .CLK    (CLK),
        .RESETn (RESETn),
        .req    ({mem_req.valid, alu_req.valid}),
        .accept (hs),
        .gnt    (gnt)
    );

    // A grant is only ever given to a valid requester, so any grant is a handshake.
    assign hs = |gnt;

    // Select the winning request's payload.
    always_comb begin
        win_wa = alu_req.wa;
        win_wd = alu_req.wd;
        if (gnt[1]) begin
            win_wa = mem_req.wa;
            win_wd = mem_req.wd;
        end
    end

    // Write stage: r0 writes consume the handshake but never assert we3.
    always_comb begin
        we3_d = hs && (win_wa != '0);
        wa3_d = wa3_q;
        wd3_d = wd3_q;
        if (hs) begin
            wa3_d = win_wa;
            wd3_d = win_wd;
        end
    end

    // Scoreboard: clear on the commit edge first, then a new issue sets (set wins).
    always_comb begin
        pending_d = pending_q;
        if (we3_q && (wa3_q != '0)) begin
            pending_d[wa3_q] = 1'b0;
        end
        if (bus.issue_valid && issue_ready && (bus.issue_wa != '0)) begin
            pending_d[bus.issue_wa] = 1'b1;
        end
    end

    // Write-port and scoreboard registers.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            we3_q     <= 1'b0;
            wa3_q     <= '0;
            wd3_q     <= '0;
            pending_q <= '0;
        end else begin
            we3_q     <= we3_d;
            wa3_q     <= wa3_d;
            wd3_q     <= wd3_d;
            pending_q <= pending_d;
        end
    end

    assign issue_ready     = !pending_q[bus.issue_wa] || (bus.issue_wa == '0);

    assign bus.alu_ready   = gnt[0];
    assign bus.mem_ready   = gnt[1];
    assign bus.issue_ready = issue_ready;
    assign bus.hazard1     = pending_q[bus.ra1] && (bus.ra1 != '0);
    assign bus.hazard2     = pending_q[bus.ra2] && (bus.ra2 != '0);
    assign bus.busy        = |pending_q;
    assign bus.we3         = we3_q;
    assign bus.wa3         = wa3_q;
    assign bus.wd3         = wd3_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: expected writes queue up at each handshake
// and are matched against the write port one cycle later.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    logic CLK = 1'b0;
    logic RESETn;
    always #5 CLK = ~CLK;

    regfile_wb_arbiter_if bus_if ();

    regfile_wb_arbiter dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus_if)
    );

    typedef struct packed {
        reg_addr_t         wa;
        logic [DATA_W-1:0] wd;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    // reference state: last grant (1 = MEM), pending bits, write in flight
    logic             m_last;
    logic [NREGS-1:0] m_pend;
    logic             m_we;
    reg_addr_t        m_wa;

    task automatic model_reset();
        m_last = 1'b1;
        m_pend = '0;
        m_we   = 1'b0;
        m_wa   = '0;
        sb.delete();
    endtask

    task automatic drive_idle();
        bus_if.alu_valid   = 1'b0;
        bus_if.alu_wa      = '0;
        bus_if.alu_wd      = '0;
        bus_if.mem_valid   = 1'b0;
        bus_if.mem_wa      = '0;
        bus_if.mem_wd      = '0;
        bus_if.issue_valid = 1'b0;
        bus_if.issue_wa    = '0;
        bus_if.ra1         = '0;
        bus_if.ra2         = '0;
    endtask

    // Advance one clock with the currently driven inputs and update the reference.
    task automatic tick();
        logic              ga, gm, ok;
        reg_addr_t         wa;
        logic [DATA_W-1:0] wd;
        exp_t              e;
        ga = bus_if.alu_valid && (!bus_if.mem_valid || m_last);
        gm = bus_if.mem_valid && !ga;
        ok = !m_pend[bus_if.issue_wa] || (bus_if.issue_wa == '0);
        wa = ga ? bus_if.alu_wa : bus_if.mem_wa;
        wd = ga ? bus_if.alu_wd : bus_if.mem_wd;
        @(posedge CLK);
        if (m_we) m_pend[m_wa] = 1'b0;
        if (bus_if.issue_valid && ok && (bus_if.issue_wa != '0)) m_pend[bus_if.issue_wa] = 1'b1;
        m_we = (ga || gm) && (wa != '0);
        m_wa = wa;
        if (m_we) begin
            e.wa = wa;
            e.wd = wd;
            sb.push_back(e);
        end
        if (ga) m_last = 1'b0;
        else if (gm) m_last = 1'b1;
        @(negedge CLK);
    endtask

    // Write-port monitor: every expected write must appear, nothing else may.
    always @(negedge CLK) begin
        exp_t e;
        if (RESETn === 1'b1) begin
            if (bus_if.we3 === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL wb_unexpected: we3=1 wa3=%0d wd3=%h, required no write", bus_if.wa3, bus_if.wd3);
                end else begin
                    e = sb.pop_front();
                    if (bus_if.wa3 !== e.wa || bus_if.wd3 !== e.wd) begin
                        n_fail++;
                        $display("FAIL wb_data: got wa3=%0d wd3=%h, required wa3=%0d wd3=%h", bus_if.wa3, bus_if.wd3, e.wa, e.wd);
                    end
                end
            end else if (sb.size() != 0) begin
                n_checks++;
                n_fail++;
                e = sb.pop_front();
                $display("FAIL wb_missing: we3=%b, required write wa3=%0d wd3=%h", bus_if.we3, e.wa, e.wd);
            end
        end
    end

    task automatic test_reset();
        drive_idle();
        RESETn = 1'b1;
        #1 RESETn = 1'b0;
        bus_if.ra1 = 5'd5;
        bus_if.ra2 = 5'd7;
        bus_if.issue_wa = 5'd3;
        #1;
        n_checks++; if (bus_if.we3 !== 1'b0) begin n_fail++; $display("FAIL rst_we3: got %b required 0", bus_if.we3); end
        n_checks++; if (bus_if.wa3 !== '0) begin n_fail++; $display("FAIL rst_wa3: got %0d required 0", bus_if.wa3); end
        n_checks++; if (bus_if.wd3 !== '0) begin n_fail++; $display("FAIL rst_wd3: got %h required 0", bus_if.wd3); end
        n_checks++; if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", bus_if.busy); end
        n_checks++; if (bus_if.hazard1 !== 1'b0 || bus_if.hazard2 !== 1'b0) begin n_fail++; $display("FAIL rst_hazard: got %b%b required 00", bus_if.hazard1, bus_if.hazard2); end
        n_checks++; if (bus_if.issue_ready !== 1'b1) begin n_fail++; $display("FAIL rst_issue_ready: got %b required 1", bus_if.issue_ready); end
        bus_if.alu_valid   = 1'b1;
        bus_if.alu_wa      = 5'd4;
        bus_if.alu_wd      = 32'h1234_5678;
        bus_if.issue_valid = 1'b1;
        #1;
        n_checks++; if (bus_if.alu_ready !== 1'b1 || bus_if.mem_ready !== 1'b0) begin n_fail++; $display("FAIL rst_grant: got alu_ready=%b mem_ready=%b required 1/0", bus_if.alu_ready, bus_if.mem_ready); end
        @(negedge CLK);
        @(negedge CLK);
        #1;
        n_checks++; if (bus_if.we3 !== 1'b0 || bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL rst_hold: got we3=%b busy=%b required 0/0", bus_if.we3, bus_if.busy); end
        drive_idle();
        model_reset();
        @(negedge CLK);
        RESETn = 1'b1;
    endtask

    task automatic test_issue_alu();
        bus_if.issue_valid = 1'b1;
        bus_if.issue_wa    = 5'd5;
        bus_if.ra1         = 5'd5;
        #1;
        n_checks++; if (bus_if.issue_ready !== 1'b1 || bus_if.hazard1 !== 1'b0) begin n_fail++; $display("FAIL ia_issue: got issue_ready=%b hazard1=%b required 1/0", bus_if.issue_ready, bus_if.hazard1); end
        tick();
        bus_if.issue_valid = 1'b0;
        bus_if.alu_valid   = 1'b1;
        bus_if.alu_wa      = 5'd5;
        bus_if.alu_wd      = 32'h0000_00AA;
        #1;
        n_checks++; if (bus_if.hazard1 !== 1'b1 || bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL ia_pending: got hazard1=%b busy=%b required 1/1", bus_if.hazard1, bus_if.busy); end
        n_checks++; if (bus_if.alu_ready !== 1'b1 || bus_if.mem_ready !== 1'b0) begin n_fail++; $display("FAIL ia_grant: got alu_ready=%b mem_ready=%b required 1/0", bus_if.alu_ready, bus_if.mem_ready); end
        tick();
        bus_if.alu_valid = 1'b0;
        #1;
        n_checks++; if (bus_if.we3 !== 1'b1 || bus_if.wa3 !== 5'd5 || bus_if.wd3 !== 32'h0000_00AA) begin n_fail++; $display("FAIL ia_write: got we3=%b wa3=%0d wd3=%h required 1/5/000000aa", bus_if.we3, bus_if.wa3, bus_if.wd3); end
        n_checks++; if (bus_if.hazard1 !== 1'b1) begin n_fail++; $display("FAIL ia_hazard_commit: got %b required 1", bus_if.hazard1); end
        tick();
        #1;
        n_checks++; if (bus_if.hazard1 !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.we3 !== 1'b0) begin n_fail++; $display("FAIL ia_cleared: got hazard1=%b busy=%b we3=%b required 0/0/0", bus_if.hazard1, bus_if.busy, bus_if.we3); end
    endtask

    task automatic test_r0();
        bus_if.mem_valid   = 1'b1;
        bus_if.mem_wa      = 5'd0;
        bus_if.mem_wd      = 32'hDEAD_BEEF;
        bus_if.issue_valid = 1'b1;
        bus_if.issue_wa    = 5'd0;
        bus_if.ra1         = 5'd0;
        bus_if.ra2         = 5'd0;
        #1;
        n_checks++; if (bus_if.mem_ready !== 1'b1 || bus_if.alu_ready !== 1'b0) begin n_fail++; $display("FAIL r0_grant: got mem_ready=%b alu_ready=%b required 1/0", bus_if.mem_ready, bus_if.alu_ready); end
        n_checks++; if (bus_if.issue_ready !== 1'b1) begin n_fail++; $display("FAIL r0_issue_ready: got %b required 1", bus_if.issue_ready); end
        tick();
        drive_idle();
        #1;
        n_checks++; if (bus_if.we3 !== 1'b0) begin n_fail++; $display("FAIL r0_we3: got %b required 0", bus_if.we3); end
        n_checks++; if (bus_if.busy !== 1'b0 || bus_if.hazard1 !== 1'b0 || bus_if.hazard2 !== 1'b0) begin n_fail++; $display("FAIL r0_pending: got busy=%b hazard=%b%b required 0/00", bus_if.busy, bus_if.hazard1, bus_if.hazard2); end
        tick();
    endtask

    task automatic test_round_robin();
        logic exp_alu [4];
        exp_alu = '{1'b1, 1'b0, 1'b1, 1'b0};
        bus_if.alu_valid = 1'b1;
        bus_if.alu_wa    = 5'd1;
        bus_if.alu_wd    = 32'h0000_0011;
        bus_if.mem_valid = 1'b1;
        bus_if.mem_wa    = 5'd2;
        bus_if.mem_wd    = 32'h0000_0022;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (bus_if.alu_ready !== exp_alu[i] || bus_if.mem_ready !== !exp_alu[i]) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got alu_ready=%b mem_ready=%b required %b/%b", i, bus_if.alu_ready, bus_if.mem_ready, exp_alu[i], !exp_alu[i]);
            end
            tick();
        end
        drive_idle();
        tick();
        tick();
    endtask

    task automatic test_waw();
        bus_if.issue_valid = 1'b1;
        bus_if.issue_wa    = 5'd7;
        bus_if.ra1         = 5'd7;
        #1;
        n_checks++; if (bus_if.issue_ready !== 1'b1) begin n_fail++; $display("FAIL waw_first: got issue_ready=%b required 1", bus_if.issue_ready); end
        tick();
        #1;
        n_checks++; if (bus_if.issue_ready !== 1'b0 || bus_if.hazard1 !== 1'b1) begin n_fail++; $display("FAIL waw_block: got issue_ready=%b hazard1=%b required 0/1", bus_if.issue_ready, bus_if.hazard1); end
        tick();
        bus_if.issue_valid = 1'b0;
        bus_if.alu_valid   = 1'b1;
        bus_if.alu_wa      = 5'd7;
        bus_if.alu_wd      = 32'h0000_0077;
        #1;
        n_checks++; if (bus_if.hazard1 !== 1'b1 || bus_if.alu_ready !== 1'b1) begin n_fail++; $display("FAIL waw_hold: got hazard1=%b alu_ready=%b required 1/1", bus_if.hazard1, bus_if.alu_ready); end
        tick();
        bus_if.alu_valid = 1'b0;
        tick();
        #1;
        n_checks++; if (bus_if.hazard1 !== 1'b0 || bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL waw_clear: got hazard1=%b busy=%b required 0/0", bus_if.hazard1, bus_if.busy); end
        // write r7 while not pending, then issue r7 on its commit edge
        bus_if.alu_valid = 1'b1;
        bus_if.alu_wd    = 32'h0000_0078;
        tick();
        bus_if.alu_valid   = 1'b0;
        bus_if.issue_valid = 1'b1;
        bus_if.issue_wa    = 5'd7;
        #1;
        n_checks++; if (bus_if.issue_ready !== 1'b1 || bus_if.we3 !== 1'b1 || bus_if.wa3 !== 5'd7) begin n_fail++; $display("FAIL waw_same_edge: got issue_ready=%b we3=%b wa3=%0d required 1/1/7", bus_if.issue_ready, bus_if.we3, bus_if.wa3); end
        tick();
        bus_if.issue_valid = 1'b0;
        #1;
        n_checks++; if (bus_if.hazard1 !== 1'b1 || bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL waw_set_wins: got hazard1=%b busy=%b required 1/1", bus_if.hazard1, bus_if.busy); end
        tick();
    endtask

    task automatic test_reset_mid();
        bus_if.issue_valid = 1'b1;
        bus_if.issue_wa    = 5'd3;
        bus_if.ra2         = 5'd3;
        tick();
        bus_if.issue_valid = 1'b0;
        bus_if.alu_valid   = 1'b1;
        bus_if.alu_wa      = 5'd9;
        bus_if.alu_wd      = 32'h0000_0099;
        tick();
        bus_if.alu_valid = 1'b0;
        #1;
        n_checks++; if (bus_if.we3 !== 1'b1 || bus_if.busy !== 1'b1 || bus_if.hazard2 !== 1'b1) begin n_fail++; $display("FAIL mid_before: got we3=%b busy=%b hazard2=%b required 1/1/1", bus_if.we3, bus_if.busy, bus_if.hazard2); end
        #1 RESETn = 1'b0;
        #1;
        n_checks++; if (bus_if.we3 !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.hazard2 !== 1'b0) begin n_fail++; $display("FAIL mid_async: got we3=%b busy=%b hazard2=%b required 0/0/0", bus_if.we3, bus_if.busy, bus_if.hazard2); end
        model_reset();
        @(negedge CLK);
        RESETn = 1'b1;
        bus_if.alu_valid = 1'b1;
        bus_if.alu_wa    = 5'd1;
        bus_if.alu_wd    = 32'h0000_0101;
        bus_if.mem_valid = 1'b1;
        bus_if.mem_wa    = 5'd2;
        bus_if.mem_wd    = 32'h0000_0202;
        #1;
        n_checks++; if (bus_if.alu_ready !== 1'b1 || bus_if.mem_ready !== 1'b0) begin n_fail++; $display("FAIL mid_first_grant: got alu_ready=%b mem_ready=%b required 1/0", bus_if.alu_ready, bus_if.mem_ready); end
        tick();
        #1;
        n_checks++; if (bus_if.mem_ready !== 1'b1 || bus_if.alu_ready !== 1'b0) begin n_fail++; $display("FAIL mid_second_grant: got alu_ready=%b mem_ready=%b required 0/1", bus_if.alu_ready, bus_if.mem_ready); end
        tick();
        drive_idle();
        tick();
        tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_issue_alu();
        test_r0();
        test_round_robin();
        test_waw();
        test_reset_mid();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d writes outstanding, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port (we3/wa3/wd3) between two writeback sources, ALU and MEM, using valid/ready handshakes and round-robin arbitration. Drives the write port from registers. Keeps a per-register pending scoreboard: issue marks a destination register pending, and the write for it clears the mark. Sits between the execute/memory stages and the register file, and gives the decode stage the hazard flags it needs to stall.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register address width; NREGS = 2**ADDR_W

Ports:
CLK  in  1  clock, rising edge
RESETn  in  1  asynchronous active-low reset
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU request granted this cycle
alu_wa  in  ADDR_W  ALU destination register
alu_wd  in  DATA_W  ALU result
mem_valid  in  1  MEM writeback request
mem_ready  out  1  MEM request granted this cycle
mem_wa  in  ADDR_W  MEM destination register
mem_wd  in  DATA_W  load data
issue_valid  in  1  decode issues an instruction that writes issue_wa
issue_wa  in  ADDR_W  destination register being issued
issue_ready  out  1  issue accepted, i.e. !pending[issue_wa] or issue_wa==0
ra1, ra2  in  ADDR_W  decode read addresses
hazard1, hazard2  out  1  pending[ra1] / pending[ra2]; forced 0 when the address is 0
busy  out  1  OR of all pending bits
we3  out  1  register file write enable, registered
wa3  out  ADDR_W  register file write address, registered
wd3  out  DATA_W  register file write data, registered

Behaviour:
- Reset (asynchronous, RESETn=0):
  - we3=0, wa3=0, wd3=0.
  - pending=0, so busy=0, hazard1=hazard2=0.
  - Round-robin pointer last_grant=MEM, so ALU wins the first conflict.
- Arbitration (combinational grant, same cycle):
  - Only one source valid: that source is granted.
  - Both valid: the source not equal to last_grant is granted.
  - Neither valid: no grant.
  - ready = grant for that source. A handshake completes when valid && ready at the rising edge.
  - last_grant updates only on a completed handshake.
  - A source must hold valid/wa/wd stable until it sees ready.
  - The write port never stalls, so a request waits at most 1 cycle.
- Write stage (registered):
  - Handshake at edge N: we3=1, wa3=wa, wd3=wd during cycle N+1. The register file commits at edge N+1.
  - No handshake at edge N: we3=0 during cycle N+1; wa3/wd3 hold their previous values.
  - Writeback to register 0 still completes the handshake and consumes arbitration, but we3 stays 0.
- Scoreboard, updated at each rising edge:
  - Set: issue_valid && issue_ready && issue_wa!=0 sets pending[issue_wa].
  - Clear: we3 && wa3!=0 clears pending[wa3]. Clearing happens on the edge where the register file commits the data, so a read in the following cycle sees the new value.
  - Set and clear of the same register on the same edge: set wins (new producer).
  - A write to a register that is not pending is legal; its clear is a no-op.
  - issue_ready=0 blocks an issue to a pending register, which prevents WAW. issue_valid with issue_ready=0 has no effect.
  - hazard flags and busy are combinational from the current pending state and the read addresses. There is no bypass.
- Reset mid-operation: all state clears immediately. In-flight writes are lost and sources must re-present them. we3 drops asynchronously.

Decomposition:
- Package regfile_pkg:
  - Constants DATA_W, ADDR_W, NREGS.
  - Typedef reg_addr_t.
  - Typedef wb_src_e {SRC_ALU, SRC_MEM}.
  - Struct wb_req_t {valid, wa, wd}.
- Sub-module rr_arbiter2:
  - Two-request round-robin arbiter holding the last_grant flop.
  - Inputs req[1:0] and accept; outputs one-hot gnt[1:0].
- The top level holds the write-stage registers and the NREGS-bit pending vector.

Test Plan:
- Reset → we3=0, wa3=0, wd3=0, busy=0, hazard1=hazard2=0, issue_ready=1. While RESETn=0, assert alu_valid → alu_ready=1 combinationally, but no state changes.
- Issue r5, then ALU writeback r5=0x0000_00AA:
  - hazard1=1 while ra1=5 until the write edge.
  - we3=1, wa3=5, wd3=0xAA one cycle after the handshake.
  - hazard1=0 and busy=0 the cycle after that.
- Both valid for 4 cycles, each re-presenting after grant (ALU r1/0x11, MEM r2/0x22) → grants ALU, MEM, ALU, MEM. Each loser sees ready=0 while the winner is granted.
- Issue r7 while r7 pending → issue_ready=0 and pending unchanged. Issue r7 on the same edge that a write of r7 commits → pending[r7] stays 1.
- MEM writeback to r0 with data 0xDEAD_BEEF → mem_ready=1, we3 stays 0, last_grant=MEM. An issue to r0 never sets pending and hazard stays 0 for ra=0.
- Pulse RESETn low with r3 pending and we3=1 → we3, pending and busy clear asynchronously. After release the next conflict grants ALU first.
